// File: rtl/lcd_pkg.sv
// lcd_pkg: shared state encoding, HD44780 command constants and timing helper for the LCD transmit path.
package lcd_pkg;
  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STROBE, S_GAP, S_DONE} state_t;
  localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
  localparam logic [7:0] LCD_CMD_HOME  = 8'h02;
  function automatic int us_to_cyc(input int clk_hz, input int us);
    return clk_hz / 1000000 * us;
  endfunction
endpackage

// File: rtl/lcd_delay_timer.sv
// lcd_delay_timer: loadable down-counter; expired is high while the count sits at zero.
module lcd_delay_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);
  logic [W-1:0] r_cnt;
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_cnt <= '0;
    else if (load) r_cnt <= load_val;
    else if (r_cnt != '0) r_cnt <= r_cnt - W'(1);
  assign expired = (r_cnt == '0);
endmodule

// File: rtl/lcd_transmit_gen.sv
// lcd_transmit_gen: HD44780 byte/nibble bus transmitter with microsecond-derived strobe timing.
// Define LCD_LONG_CMD_EN to stretch the final wait to LONG_US after clear/home commands.
module lcd_transmit_gen
  import lcd_pkg::*;
#(
  parameter int CLK_HZ  = 10000000,
  parameter int BUS_W   = 8,
  parameter int EN_US   = 1,
  parameter int HOLD_US = 50,
  parameter int NIB_US  = 2,
  parameter int LONG_US = 1600
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       data,
  input  logic             cd,
  input  logic             nib_only,
  output logic             ready,
  output logic [BUS_W-1:0] lcd_data,
  output logic             rs,
  output logic             en,
  output logic             done_tick
);
  localparam int EN_CYC   = us_to_cyc(CLK_HZ, EN_US);
  localparam int HOLD_CYC = us_to_cyc(CLK_HZ, HOLD_US);
  localparam int NIB_CYC  = us_to_cyc(CLK_HZ, NIB_US);
  localparam int LONG_CYC = us_to_cyc(CLK_HZ, LONG_US);
  localparam int M1 = EN_CYC > NIB_CYC ? EN_CYC : NIB_CYC;
  localparam int M2 = M1 > HOLD_CYC ? M1 : HOLD_CYC;
`ifdef LCD_LONG_CMD_EN
  localparam int MAX_CYC = M2 > LONG_CYC ? M2 : LONG_CYC;
`else
  localparam int MAX_CYC = M2;
`endif
  localparam int CW = $clog2(MAX_CYC + 1);

  if (CLK_HZ % 1000000 != 0 || !(BUS_W == 8 || BUS_W == 4) ||
      EN_CYC < 1 || NIB_CYC < 1 || HOLD_CYC < 1 || LONG_CYC < 1) begin : g_param_err
    $error("lcd_transmit_gen: illegal parameter set");
  end

  state_t r_state, w_next;
  logic [7:0] r_byte;
  logic [BUS_W-1:0] r_lcd_data;
  logic r_rs, r_last;
  logic w_load, w_expired;
  logic [CW-1:0] w_load_val, w_final_val;

  // Timed states last N cycles: the counter is loaded with N-1 on entry.
  lcd_delay_timer #(.W(CW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (w_load),
    .load_val (w_load_val),
    .expired  (w_expired)
  );

`ifdef LCD_LONG_CMD_EN
  logic r_nib_only;
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_nib_only <= 1'b0;
    else if (r_state == S_IDLE && start) r_nib_only <= nib_only;
  assign w_final_val = (!r_rs && (BUS_W == 8 || !r_nib_only) &&
                        (r_byte == LCD_CMD_CLEAR || r_byte[7:1] == LCD_CMD_HOME[7:1]))
                       ? CW'(LONG_CYC - 1) : CW'(HOLD_CYC - 1);
`else
  assign w_final_val = CW'(HOLD_CYC - 1);
`endif

  always_ff @(posedge clk or negedge rst)
    if (!rst) r_state <= S_IDLE;
    else r_state <= w_next;

  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    w_load_val = '0;
    case (r_state)
      S_IDLE:   w_next = start ? S_SETUP : S_IDLE;
      S_SETUP: begin
        w_next     = S_STROBE;
        w_load     = 1'b1;
        w_load_val = CW'(EN_CYC - 1);
      end
      S_STROBE: if (w_expired) begin
        w_next     = S_GAP;
        w_load     = 1'b1;
        w_load_val = r_last ? w_final_val : CW'(NIB_CYC - 1);
      end
      S_GAP:    if (w_expired) w_next = r_last ? S_DONE : S_SETUP;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Bus values are loaded on the edge entering SETUP so they are valid for the whole setup cycle.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_byte     <= '0;
      r_rs       <= 1'b0;
      r_last     <= 1'b0;
      r_lcd_data <= '0;
    end else if (r_state == S_IDLE && start) begin
      r_byte     <= data;
      r_rs       <= cd;
      r_last     <= (BUS_W == 8) || nib_only;
      r_lcd_data <= data[7 -: BUS_W];
    end else if (r_state == S_GAP && w_expired && !r_last) begin
      r_last     <= 1'b1;
      r_lcd_data <= r_byte[BUS_W-1:0];
    end

  assign ready     = (r_state == S_IDLE);
  assign en        = (r_state == S_STROBE);
  assign done_tick = (r_state == S_DONE);
  assign rs        = r_rs;
  assign lcd_data  = r_lcd_data;
endmodule

// File: tb/tb_lcd_transmit_gen.sv
// tb_lcd_transmit_gen: scoreboard bench driving an 8-bit and a 4-bit transmitter with random transfers.
module tb_lcd_transmit_gen;
  localparam int EN = 2, NIB = 3, HOLD = 5, LONG = 20;
`ifdef LCD_LONG_CMD_EN
  localparam bit LONG_ON = 1'b1;
`else
  localparam bit LONG_ON = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b0;
  logic [1:0] st = '0, cdv = '0, nbv = '0;
  logic [7:0] d0 = '0, d1 = '0;
  logic [1:0] rdy, rsv, env, dn;
  logic [7:0] ld8;
  logic [3:0] ld4;
  int cyc = 0, pass_n = 0, tot_n = 0;

  lcd_transmit_gen #(.CLK_HZ(1000000), .BUS_W(8), .EN_US(2), .HOLD_US(5), .NIB_US(3), .LONG_US(20)) u8 (
    .clk(clk), .rst(rst), .start(st[0]), .data(d0), .cd(cdv[0]), .nib_only(nbv[0]),
    .ready(rdy[0]), .lcd_data(ld8), .rs(rsv[0]), .en(env[0]), .done_tick(dn[0]));
  lcd_transmit_gen #(.CLK_HZ(1000000), .BUS_W(4), .EN_US(2), .HOLD_US(5), .NIB_US(3), .LONG_US(20)) u4 (
    .clk(clk), .rst(rst), .start(st[1]), .data(d1), .cd(cdv[1]), .nib_only(nbv[1]),
    .ready(rdy[1]), .lcd_data(ld4), .rs(rsv[1]), .en(env[1]), .done_tick(dn[1]));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  task automatic chk(input string nm, input int act, input int exp);
    tot_n++;
    if (act == exp) pass_n++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  function automatic int ldv(input int k);
    return k != 0 ? int'(ld4) : int'(ld8);
  endfunction

  typedef struct {int k; logic [7:0] d; logic rs;} strb_t;
  typedef struct {int k; int c;} done_t;
  strb_t qs[$];
  done_t qd[$];
  strb_t cur[2];
  done_t de;
  int w[2];
  logic [1:0] enp = '0;

  // Monitor: every strobe and done_tick the DUTs produce must match the next queued expectation.
  always @(negedge clk) begin
    if (!rst) enp = '0;
    else for (int k = 0; k < 2; k++) begin
      if (env[k] && !enp[k]) begin
        w[k] = 0;
        if (qs.size() == 0) begin
          tot_n++;
          $display("FAIL unexpected strobe on dut%0d at cycle %0d", k, cyc);
          cur[k] = '{k, 8'hxx, 1'bx};
        end else begin
          cur[k] = qs.pop_front();
          chk("strobe_dut", k, cur[k].k);
        end
      end
      if (env[k]) begin
        w[k]++;
        chk("strobe_data", ldv(k), int'(cur[k].d));
        chk("strobe_rs", int'(rsv[k]), int'(cur[k].rs));
      end
      if (!env[k] && enp[k]) chk("strobe_width", w[k], EN);
      if (dn[k]) begin
        chk("done_not_idle", int'(rdy[k]), 0);
        if (qd.size() == 0) begin
          tot_n++;
          $display("FAIL unexpected done_tick on dut%0d at cycle %0d", k, cyc);
        end else begin
          de = qd.pop_front();
          chk("done_dut", k, de.k);
          chk("done_cycle", cyc, de.c);
        end
      end
      enp[k] = env[k];
    end
  end

  task automatic drive(input int k, input logic s, input logic [7:0] d, input logic c, input logic n);
    st[k] = s; cdv[k] = c; nbv[k] = n;
    if (k == 0) d0 = d; else d1 = d;
  endtask

  // Reference: each nibble costs setup+strobe, nibbles are separated by NIB, then a final wait and DONE.
  task automatic xfer(input int k, input logic [7:0] d, input logic c, input logic n, input bit hold);
    int nn, fg, lat, c0;
    bit full;
    logic [7:0] last;
    full = (k == 0) || !n;
    nn = full && k == 1 ? 2 : 1;
    fg = (LONG_ON && !c && full && d >= 8'h01 && d <= 8'h03) ? LONG : HOLD;
    lat = nn * (1 + EN) + (nn - 1) * NIB + fg + 1;
    if (k == 0) last = d;
    else last = {4'h0, (nn == 2 ? d[3:0] : d[7:4])};
    if (k == 0) qs.push_back('{0, d, c});
    else begin
      qs.push_back('{1, {4'h0, d[7:4]}, c});
      if (nn == 2) qs.push_back('{1, {4'h0, d[3:0]}, c});
    end
    c0 = cyc;
    qd.push_back('{k, c0 + lat});
    drive(k, 1'b1, d, c, n);
    for (int i = 1; i <= lat; i++) begin
      @(negedge clk);
      if (i == 1) chk("busy_ready", int'(rdy[k]), 0);
      drive(k, hold ? 1'b1 : 1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    end
    @(negedge clk);
    drive(k, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("ready_after_done", int'(rdy[k]), 1);
    chk("retain_data", ldv(k), int'(last));
    chk("retain_rs", int'(rsv[k]), int'(c));
  endtask

  task automatic rtest(input int k);
    drive(k, 1'b1, 8'hA5, 1'b1, 1'b0);
    qs.push_back('{k, (k == 0 ? 8'hA5 : 8'h0A), 1'b1});
    @(negedge clk);
    drive(k, 1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rst_en", int'(env[k]), 0);
    chk("rst_rs", int'(rsv[k]), 0);
    chk("rst_data", ldv(k), 0);
    chk("rst_done", int'(dn[k]), 0);
    chk("rst_ready", int'(rdy[k]), 1);
    qs.delete();
    @(negedge clk);
    #2 rst = 1'b1;
    repeat (20) @(negedge clk);
    chk("post_rst_ready", int'(rdy[k]), 1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("init_ready", int'(rdy[k]), 1);
      chk("init_en", int'(env[k]), 0);
      chk("init_rs", int'(rsv[k]), 0);
      chk("init_data", ldv(k), 0);
      chk("init_done", int'(dn[k]), 0);
    end
    #2 rst = 1'b1;
    @(negedge clk);
    xfer(0, 8'h41, 1'b1, 1'b0, 1'b0);
    xfer(1, 8'h28, 1'b0, 1'b0, 1'b0);
    xfer(1, 8'h30, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 2; k++) begin
      xfer(k, 8'h01, 1'b0, 1'b0, 1'b0);
      xfer(k, 8'h01, 1'b1, 1'b0, 1'b0);
      xfer(k, 8'h02, 1'b0, 1'b0, 1'b1);
      xfer(k, 8'h03, 1'b0, 1'b1, 1'b1);
      xfer(k, 8'h5C, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 20; i++)
        xfer(k, (i % 5 == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom),
             1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0));
      rtest(k);
      xfer(k, 8'hC3, 1'b0, 1'b0, 1'b0);
    end
    repeat (30) @(negedge clk);
    chk("strobe_queue_empty", qs.size(), 0);
    chk("done_queue_empty", qd.size(), 0);
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule
